// File: rtl/exc_collector_if.sv
// MEM-stage to CP0 exception bus.
//   master : pipeline side, drives the MEM-stage instruction info and reads
//            the exception report.
//   slave  : exception collector, reads the MEM-stage info and drives the
//            exception code, bad address, PC and delay-slot flag to CP0.
interface exc_collector_if;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delay_i;
    logic [7:0]  mem_exc_i;
    logic [31:0] mem_daddr_i;
    logic [4:0]  exccode_o;
    logic [31:0] exc_badvaddr_o;
    logic [31:0] pc_o;
    logic        in_delay_o;

    modport master (
        output mem_valid_i, mem_pc_i, mem_in_delay_i, mem_exc_i, mem_daddr_i,
        input  exccode_o, exc_badvaddr_o, pc_o, in_delay_o
    );

    modport slave (
        input  mem_valid_i, mem_pc_i, mem_in_delay_i, mem_exc_i, mem_daddr_i,
        output exccode_o, exc_badvaddr_o, pc_o, in_delay_o
    );
endinterface

// File: rtl/exc_collector.sv
// MEM-stage exception collector and interrupt front end.
// Ports:
//   cpu_clk_50M, cpu_rst_n : clock, async active-low reset
//   int_raw_i              : asynchronous external interrupt lines
//   timer_int_i            : CP0 timer interrupt, merged into int_o[5]
//   int_o                  : synchronised interrupt bus to CP0 cause[15:10]
//   status_i, cause_i      : CP0 status / cause for interrupt pending
//   mem_if (slave)         : MEM-stage instruction info in, exception bus out
//
// FSM states:
//   state | meaning
//   IDLE  | exceptions from the MEM instruction are reported
//   BLANK | a report was just made; outputs held at EXC_NONE until blank_cnt hits 0
module exc_collector #(
    parameter int SYNC_STAGES  = 2,
    parameter int BLANK_CYCLES = 1
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic [5:0]  int_raw_i,
    input  logic        timer_int_i,
    output logic [5:0]  int_o,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    exc_collector_if.slave mem_if
);

    localparam logic [4:0] EXC_INT   = 5'h00;
    localparam logic [4:0] EXC_ADEL  = 5'h04;
    localparam logic [4:0] EXC_ADES  = 5'h05;
    localparam logic [4:0] EXC_SYS   = 5'h08;
    localparam logic [4:0] EXC_BREAK = 5'h09;
    localparam logic [4:0] EXC_RI    = 5'h0A;
    localparam logic [4:0] EXC_OV    = 5'h0C;
    localparam logic [4:0] EXC_ERET  = 5'h0E;
    localparam logic [4:0] EXC_NONE  = 5'h10;

    typedef enum logic {IDLE, BLANK} state_t;

    state_t      state_q, state_d;
    logic [3:0]  blank_cnt_q, blank_cnt_d;
    logic [5:0]  sync_q [SYNC_STAGES];

    logic        int_pend;
    logic [4:0]  sel_code;
    logic [31:0] sel_addr;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;

    wire unused_bits = &{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 6'b0;
        end else begin
            sync_q[0] <= int_raw_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Timer interrupt is already synchronous to this clock, so it bypasses the chain.
    assign int_o = {sync_q[SYNC_STAGES-1][5] | timer_int_i, sync_q[SYNC_STAGES-1][4:0]};

    assign int_pend = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));

    always_comb begin
        sel_code = EXC_NONE;
        sel_addr = 32'h0;
        if (mem_if.mem_valid_i) begin
            if (int_pend) begin
                sel_code = EXC_INT;
            end else if (mem_if.mem_exc_i[0]) begin
                sel_code = EXC_ADEL;
                sel_addr = mem_if.mem_pc_i;
            end else if (mem_if.mem_exc_i[1]) begin
                sel_code = EXC_RI;
            end else if (mem_if.mem_exc_i[2]) begin
                sel_code = EXC_OV;
            end else if (mem_if.mem_exc_i[3]) begin
                sel_code = EXC_SYS;
            end else if (mem_if.mem_exc_i[4]) begin
                sel_code = EXC_BREAK;
            end else if (mem_if.mem_exc_i[5]) begin
                sel_code = EXC_ERET;
            end else if (mem_if.mem_exc_i[6]) begin
                sel_code = EXC_ADEL;
                sel_addr = mem_if.mem_daddr_i;
            end else if (mem_if.mem_exc_i[7]) begin
                sel_code = EXC_ADES;
                sel_addr = mem_if.mem_daddr_i;
            end
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q     <= IDLE;
            blank_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        exccode     = EXC_NONE;
        badvaddr    = 32'h0;
        case (state_q)
            IDLE: begin
                exccode  = sel_code;
                badvaddr = sel_addr;
                if (sel_code != EXC_NONE) begin
                    state_d     = BLANK;
                    blank_cnt_d = 4'(BLANK_CYCLES - 1);
                end
            end
            BLANK: begin
                if (blank_cnt_q == 4'd0) state_d = IDLE;
                else                     blank_cnt_d = blank_cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // The exception path is combinational, so the reset gate must be too.
    assign mem_if.exccode_o      = cpu_rst_n ? exccode : EXC_NONE;
    assign mem_if.exc_badvaddr_o = cpu_rst_n ? badvaddr : 32'h0;
    assign mem_if.pc_o           = cpu_rst_n ? mem_if.mem_pc_i : 32'h0;
    assign mem_if.in_delay_o     = cpu_rst_n & mem_if.mem_in_delay_i;

endmodule

// File: tb/tb_exc_collector.sv
module tb_exc_collector;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  int_raw;
    logic        timer_int;
    logic [31:0] status;
    logic [31:0] cause;
    logic [5:0]  int1, int2;
    logic [31:0] cause2;

    int errors = 0;
    int checks = 0;

    exc_collector_if m1();
    exc_collector_if m2();

    // cause mirrors the synchronised interrupt bus, as CP0 would.
    assign cause  = {16'h0, int1, 10'h0};
    assign cause2 = {16'h0, int2, 10'h0};

    exc_collector #(.SYNC_STAGES(2), .BLANK_CYCLES(1)) dut1 (
        .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .int_raw_i(int_raw),
        .timer_int_i(timer_int), .int_o(int1), .status_i(status),
        .cause_i(cause), .mem_if(m1.slave)
    );

    exc_collector #(.SYNC_STAGES(2), .BLANK_CYCLES(3)) dut2 (
        .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .int_raw_i(int_raw),
        .timer_int_i(timer_int), .int_o(int2), .status_i(status),
        .cause_i(cause2), .mem_if(m2.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic [7:0] exc, input logic [31:0] pc,
                          input logic [31:0] daddr, input logic dly);
        m1.mem_valid_i    = v;
        m1.mem_exc_i      = exc;
        m1.mem_pc_i       = pc;
        m1.mem_daddr_i    = daddr;
        m1.mem_in_delay_i = dly;
        #1;
    endtask

    task automatic flush1();
        drive1(1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
        step();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        int_raw = 6'h0;
        timer_int = 1'b1;
        status = 32'h0;
        m2.mem_valid_i = 1'b0; m2.mem_exc_i = 8'h0; m2.mem_pc_i = 32'h0;
        m2.mem_daddr_i = 32'h0; m2.mem_in_delay_i = 1'b0;
        drive1(1'b1, 8'h08, 32'h1234_5678, 32'h0, 1'b1);

        // Reset values, with inputs live
        check("rst_exccode", {27'h0, m1.exccode_o}, 32'h10);
        check("rst_badv", m1.exc_badvaddr_o, 32'h0);
        check("rst_pc", m1.pc_o, 32'h0);
        check("rst_dly", {31'h0, m1.in_delay_o}, 32'h0);
        check("rst_int_timer", {26'h0, int1}, 32'h20);
        timer_int = 1'b0;
        #1;
        check("rst_int_zero", {26'h0, int1}, 32'h0);

        // Reset mid-BLANK
        step();
        rst_n = 1'b1;
        #1;
        check("sys_first", {27'h0, m1.exccode_o}, 32'h08);
        check("pc_pass", m1.pc_o, 32'h1234_5678);
        step();
        check("sys_blank", {27'h0, m1.exccode_o}, 32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("midblank_rst_code", {27'h0, m1.exccode_o}, 32'h10);
        check("midblank_rst_int", {26'h0, int1}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("after_rst_no_blank", {27'h0, m1.exccode_o}, 32'h08);
        flush1();

        // Interrupt on line 2 (cause[12], unmasked by status[12])
        status = 32'h1000_1001;
        drive1(1'b1, 8'h00, 32'h0000_0100, 32'h0, 1'b0);
        check("no_int_yet", {27'h0, m1.exccode_o}, 32'h10);
        int_raw = 6'b000100;
        step();
        check("sync_edge_k", {26'h0, int1}, 32'h0);
        check("sync_edge_k_code", {27'h0, m1.exccode_o}, 32'h10);
        step();
        check("sync_edge_k1", {26'h0, int1}, 32'h04);
        check("int_taken", {27'h0, m1.exccode_o}, 32'h00);
        check("int_badv", m1.exc_badvaddr_o, 32'h0);
        step();
        check("int_blank", {27'h0, m1.exccode_o}, 32'h10);
        step();
        drive1(1'b0, 8'h00, 32'h0000_0104, 32'h0, 1'b0);
        check("int_invalid", {27'h0, m1.exccode_o}, 32'h10);
        step();
        status = 32'h1000_1003;
        drive1(1'b1, 8'h00, 32'h0000_0108, 32'h0, 1'b0);
        check("int_exl", {27'h0, m1.exccode_o}, 32'h10);
        step();
        check("int_exl_hold", {27'h0, m1.exccode_o}, 32'h10);
        status = 32'h1000_1001;
        #1;
        check("int_exl_clear", {27'h0, m1.exccode_o}, 32'h00);
        int_raw = 6'h0;
        status = 32'h0;
        flush1();
        step();

        // Several flags: RI wins over OV and load misaligned
        drive1(1'b1, 8'b0100_0110, 32'h0000_0200, 32'h8000_0003, 1'b0);
        check("multi_code", {27'h0, m1.exccode_o}, 32'h0A);
        check("multi_badv", m1.exc_badvaddr_o, 32'h0);
        flush1();

        // Store misaligned in a delay slot
        drive1(1'b1, 8'h80, 32'hBFC0_0100, 32'h8000_0102, 1'b1);
        check("ades_code", {27'h0, m1.exccode_o}, 32'h05);
        check("ades_badv", m1.exc_badvaddr_o, 32'h8000_0102);
        check("ades_pc", m1.pc_o, 32'hBFC0_0100);
        check("ades_dly", {31'h0, m1.in_delay_o}, 32'h1);
        flush1();

        // Fetch misaligned wins over load misaligned; address is the PC
        drive1(1'b1, 8'h41, 32'h0000_1002, 32'h8000_0005, 1'b0);
        check("fadel_code", {27'h0, m1.exccode_o}, 32'h04);
        check("fadel_badv", m1.exc_badvaddr_o, 32'h0000_1002);
        flush1();

        // Load misaligned alone; address is the data address
        drive1(1'b1, 8'h40, 32'h0000_1004, 32'h8000_0005, 1'b0);
        check("ladel_code", {27'h0, m1.exccode_o}, 32'h04);
        check("ladel_badv", m1.exc_badvaddr_o, 32'h8000_0005);
        flush1();

        // Break beats ERET
        drive1(1'b1, 8'h30, 32'h0000_1008, 32'h0, 1'b0);
        check("break_code", {27'h0, m1.exccode_o}, 32'h09);
        flush1();

        // BLANK_CYCLES=3: ERET, three blanked syscalls, then syscall reported
        m2.mem_valid_i = 1'b1;
        m2.mem_exc_i   = 8'h20;
        #1;
        check("b3_eret", {27'h0, m2.exccode_o}, 32'h0E);
        step();
        m2.mem_exc_i = 8'h08;
        #1;
        check("b3_blank1", {27'h0, m2.exccode_o}, 32'h10);
        step();
        check("b3_blank2", {27'h0, m2.exccode_o}, 32'h10);
        step();
        check("b3_blank3", {27'h0, m2.exccode_o}, 32'h10);
        step();
        check("b3_sys", {27'h0, m2.exccode_o}, 32'h08);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
